// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
//
// Sums a stream of unsigned products (from the pipelined Vedic multiplier)
// into one dot-product element of the matrix multiplier. After cfg_len terms
// the finished sum is published on acc_out with a one-cycle acc_valid pulse
// and a sticky overflow flag. The next dot product may start in the very
// cycle the result is published, so results can stream back-to-back.
//
// Ports:
//   clk         in   1        rising-edge clock
//   reset       in   1        synchronous, active-high reset
//   cfg_len     in   LEN_W    terms per dot product (0 acts as 1), sampled on term 1
//   clear       in   1        synchronous abort of the partial sum, no result
//   prod        in   PROD_W   unsigned product
//   prod_valid  in   1        qualifier for prod
//   acc_out     out  ACC_W    last finished sum, held until the next result
//   acc_valid   out  1        one-cycle pulse marking a new acc_out
//   overflow    out  1        a carry left ACC_W during the published dot product
//   busy        out  1        a dot product is partially accumulated

module dot_product_accumulator #(
   parameter int PROD_W = 32,
   parameter int ACC_W  = 40,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              clear,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_valid,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   output logic              overflow,
   output logic              busy
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t             state;
   state_t             next_state;

   logic [ACC_W-1:0]   acc;
   logic [LEN_W-1:0]   cnt;
   logic [LEN_W-1:0]   len_q;
   logic               ovf_q;

   logic [LEN_W-1:0]   eff_len;
   logic [LEN_W-1:0]   cur_len;
   logic [LEN_W-1:0]   cnt_next;
   logic [ACC_W:0]     sum;
   logic               last;

   // A zero length would never terminate, so it is promoted to one term.
   // While idle the incoming term is term 1, so its length comes straight
   // from cfg_len; during accumulation the latched length is used.
   assign eff_len  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
   assign cur_len  = (state == IDLE) ? eff_len : len_q;
   assign cnt_next = cnt + 1'b1;
   assign last     = (cnt_next == cur_len);

   // One extra bit captures the carry out of the accumulator width.
   assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic: an abort or the last term always returns to IDLE;
   // a non-final term (including term 1) moves into or stays in ACCUM.
   always_comb begin
      next_state = state;
      if (clear)
         next_state = IDLE;
      else if (prod_valid)
         next_state = last ? IDLE : ACCUM;
   end

   // Output logic: busy is a pure decode of the registered state.
   always_comb begin
      busy = (state == ACCUM);
   end

   // Datapath. The final term is never written into acc: its sum goes
   // directly to acc_out, and acc restarts at zero so the following cycle
   // can already accept term 1 of the next dot product. acc_out and
   // overflow are only touched when a result is published or on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         cnt       <= '0;
         len_q     <= '0;
         ovf_q     <= 1'b0;
         acc_out   <= '0;
         acc_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         acc_valid <= 1'b0;
         if (clear) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
         end else if (prod_valid) begin
            if (last) begin
               acc_out   <= sum[ACC_W-1:0];
               overflow  <= ovf_q | sum[ACC_W];
               acc_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
               ovf_q     <= 1'b0;
            end else begin
               acc   <= sum[ACC_W-1:0];
               cnt   <= cnt_next;
               ovf_q <= ovf_q | sum[ACC_W];
               if (state == IDLE)
                  len_q <= eff_len;
            end
         end
      end
   end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb_dot_product_accumulator
//
// Directed bench for dot_product_accumulator. The DUT is built with a 33-bit
// accumulator so the carry-out path can be driven with three full-scale
// products. Stimulus pushes the hand-computed result (value, overflow flag and
// the cycle the pulse must appear in) into a scoreboard queue; a separate
// monitor pops and compares on every acc_valid pulse.

module tb_dot_product_accumulator;

   localparam int PROD_W = 32;
   localparam int ACC_W  = 33;
   localparam int LEN_W  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [LEN_W-1:0]  cfg_len;
   logic              clear;
   logic [PROD_W-1:0] prod;
   logic              prod_valid;
   logic [ACC_W-1:0]  acc_out;
   logic              acc_valid;
   logic              overflow;
   logic              busy;

   typedef struct {
      logic [ACC_W-1:0] acc;
      logic             ovf;
      int               at;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   failed = 0;
   int   cyc    = 0;

   dot_product_accumulator #(
      .PROD_W(PROD_W),
      .ACC_W (ACC_W),
      .LEN_W (LEN_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_len   (cfg_len),
      .clear     (clear),
      .prod      (prod),
      .prod_valid(prod_valid),
      .acc_out   (acc_out),
      .acc_valid (acc_valid),
      .overflow  (overflow),
      .busy      (busy)
   );

   // Free-running clock and a cycle counter used to time result pulses.
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Drives one cycle of inputs just after the falling edge, so the DUT
   // samples them on the next rising edge and outputs read here reflect the
   // previous cycle's inputs.
   task automatic applyStimulus(input logic v, input logic [PROD_W-1:0] p,
                                input logic [LEN_W-1:0] len, input logic clr, input logic rst);
      @(negedge clk);
      prod_valid = v;
      prod       = p;
      cfg_len    = len;
      clear      = clr;
      reset      = rst;
   endtask

   // Called right after the last term is driven: the pulse must be visible
   // one cycle after that term is sampled.
   task automatic expectResult(input logic [ACC_W-1:0] a, input logic o);
      exp_t e;
      e.acc = a;
      e.ovf = o;
      e.at  = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: every acc_valid pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (acc_valid === 1'b1) begin
            if (sb.size() == 0) begin
               tests++;
               failed++;
               $display("[TB] FAIL unexpected_pulse: acc_out=0x%0h at cycle %0d, expected no result", acc_out, cyc);
            end else begin
               e = sb.pop_front();
               checkOutput("acc_out", 64'(acc_out), 64'(e.acc));
               checkOutput("overflow", 64'(overflow), 64'(e.ovf));
               checkOutput("pulse_cycle", 64'(cyc), 64'(e.at));
            end
         end
      end
   end

   initial begin
      reset      = 1'b1;
      clear      = 1'b0;
      prod_valid = 1'b0;
      prod       = '0;
      cfg_len    = '0;

      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      idle();
      checkOutput("reset_acc_out", 64'(acc_out), 64'd0);
      checkOutput("reset_acc_valid", 64'(acc_valid), 64'd0);
      checkOutput("reset_overflow", 64'(overflow), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);

      // Gapped stream; cfg_len changes after term 1 must be ignored.
      applyStimulus(1'b1, 32'd1, 8'd4, 1'b0, 1'b0);
      idle();
      checkOutput("gap_busy_after_t1", 64'(busy), 64'd1);
      applyStimulus(1'b1, 32'd2, 8'd9, 1'b0, 1'b0);
      idle();
      applyStimulus(1'b1, 32'd3, 8'd2, 1'b0, 1'b0);
      idle();
      checkOutput("gap_busy_mid", 64'(busy), 64'd1);
      applyStimulus(1'b1, 32'd4, 8'd1, 1'b0, 1'b0);
      expectResult(33'd10, 1'b0);
      idle();
      checkOutput("gap_busy_fall", 64'(busy), 64'd0);
      idle();
      checkOutput("gap_pulse_width", 64'(acc_valid), 64'd0);

      // Back-to-back length-2 dot products with no gaps.
      applyStimulus(1'b1, 32'd5, 8'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'd7, 8'd2, 1'b0, 1'b0);
      expectResult(33'd12, 1'b0);
      applyStimulus(1'b1, 32'd100, 8'd2, 1'b0, 1'b0);
      checkOutput("b2b_busy_at_result", 64'(busy), 64'd0);
      applyStimulus(1'b1, 32'd200, 8'd2, 1'b0, 1'b0);
      expectResult(33'd300, 1'b0);
      idle();

      // Length 0 and 1 both complete in a single term.
      applyStimulus(1'b1, 32'hFFFF_FFFF, 8'd0, 1'b0, 1'b0);
      expectResult(33'h0_FFFF_FFFF, 1'b0);
      idle();
      checkOutput("len0_busy", 64'(busy), 64'd0);
      applyStimulus(1'b1, 32'hFFFF_FFFF, 8'd1, 1'b0, 1'b0);
      expectResult(33'h0_FFFF_FFFF, 1'b0);
      idle();
      checkOutput("len1_busy", 64'(busy), 64'd0);

      // Carry out of 33 bits on the third term, then a clean result.
      applyStimulus(1'b1, 32'hFFFF_FFFF, 8'd3, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hFFFF_FFFF, 8'd3, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hFFFF_FFFF, 8'd3, 1'b0, 1'b0);
      expectResult(33'h0_FFFF_FFFD, 1'b1);
      idle();
      applyStimulus(1'b1, 32'd1, 8'd1, 1'b0, 1'b0);
      expectResult(33'd1, 1'b0);
      idle();

      // Abort after two terms; clear wins over the third term.
      applyStimulus(1'b1, 32'd10, 8'd4, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'd20, 8'd4, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'd30, 8'd4, 1'b1, 1'b0);
      idle();
      checkOutput("clear_busy", 64'(busy), 64'd0);
      checkOutput("clear_holds_acc_out", 64'(acc_out), 64'd1);
      applyStimulus(1'b1, 32'd3, 8'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'd4, 8'd2, 1'b0, 1'b0);
      expectResult(33'd7, 1'b0);
      idle();
      idle();

      // Reset after three of five terms, with a product offered alongside.
      applyStimulus(1'b1, 32'd1, 8'd5, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'd2, 8'd5, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'd3, 8'd5, 1'b0, 1'b0);
      idle();
      checkOutput("pre_reset_busy", 64'(busy), 64'd1);
      applyStimulus(1'b1, 32'd50, 8'd5, 1'b0, 1'b1);
      idle();
      checkOutput("midreset_acc_out", 64'(acc_out), 64'd0);
      checkOutput("midreset_acc_valid", 64'(acc_valid), 64'd0);
      checkOutput("midreset_overflow", 64'(overflow), 64'd0);
      checkOutput("midreset_busy", 64'(busy), 64'd0);
      applyStimulus(1'b1, 32'd9, 8'd1, 1'b0, 1'b0);
      expectResult(33'd9, 1'b0);

      // Let the monitor drain the scoreboard, bounded, and watch for strays.
      for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
      repeat (4) idle();
      checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
